// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 transmit path: scheduler state encoding,
// byte-source identifiers, well-known host command bytes and a timer sizing helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3
    } state_t;

    localparam logic SRC_FIFO = 1'b0;
    localparam logic SRC_CMD  = 1'b1;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;

    // Bits needed for a counter that can reach 'limit' (at least one bit).
    function automatic int unsigned timer_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ps2_rr_arbiter.sv
// Two-requester round-robin arbiter (scan-code FIFO vs host command port).
// The pointer only moves when both sources compete and the grant is taken,
// so a lone requester never steals the other source's next turn.
module ps2_rr_arbiter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_fifo,
    input  logic req_cmd,
    input  logic update,
    output logic grant_valid,
    output logic grant_src
);

    logic ptr_reg;
    logic ptr_next;

    // Round-robin pointer; after reset the FIFO has priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= SRC_FIFO;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Grant decode and pointer advance on a contested, accepted grant.
    always_comb begin
        grant_valid = req_fifo | req_cmd;
        grant_src   = SRC_FIFO;
        ptr_next    = ptr_reg;
        if (req_fifo && req_cmd) begin
            grant_src = ptr_reg;
            if (update) begin
                ptr_next = ~ptr_reg;
            end
        end else if (req_cmd) begin
            grant_src = SRC_CMD;
        end
    end

endmodule

// File: rtl/ps2_tx_scheduler.sv
// Shares the PS/2 host transmitter between the scan-code FIFO and the host
// command port: arbitrate, pop one byte, start, wait for completion, retry on
// failure, then hold an inter-byte gap.
// Optional statistics outputs (sent_cnt/drop_cnt) are built when the macro
// PS2_SCHED_STATS_EN is defined.
module ps2_tx_scheduler
    import ps2_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    input  logic        tx_busy,
    input  logic        tx_done,
    input  logic        tx_err,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [2:0]  state
`ifdef PS2_SCHED_STATS_EN
    ,
    output logic [15:0] sent_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int unsigned GAP_W   = timer_width(GAP_CYCLES);
    localparam int unsigned TO_W    = timer_width(TIMEOUT_CYCLES);
    localparam int unsigned RETRY_W = timer_width(MAX_RETRY);

    state_t               state_reg;
    state_t               state_next;
    logic [7:0]           tx_data_reg;
    logic [RETRY_W-1:0]   retry_cnt_reg;
    logic                 retry_pend_reg;
    logic [GAP_W-1:0]     gap_cnt_reg;
    logic [TO_W-1:0]      to_cnt_reg;

    logic grant_valid;
    logic grant_src;
    logic take;
    logic wait_done;
    logic wait_fail;
    logic can_retry;
    logic byte_drop;
    logic to_hit;
    logic gap_hit;

    ps2_rr_arbiter u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_fifo    (~fifo_empty),
        .req_cmd     (cmd_valid),
        .update      (take),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    // A grant is taken only from IDLE with the transmitter free.
    assign take      = (state_reg == ST_IDLE) && !tx_busy && grant_valid;
    // Done has priority over an error in the same cycle.
    assign wait_done = (state_reg == ST_WAIT) && tx_done;
    assign to_hit    = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
    assign wait_fail = (state_reg == ST_WAIT) && !tx_done && (tx_err || to_hit);
    assign can_retry = (retry_cnt_reg < RETRY_W'(MAX_RETRY));
    assign byte_drop = wait_fail && !can_retry;
    assign gap_hit   = (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (take) state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT:  if (wait_done || wait_fail) state_next = ST_GAP;
            ST_GAP:   if (gap_hit) state_next = retry_pend_reg ? ST_START : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Strobes; gated by reset so nothing is popped or started on a reset cycle.
    always_comb begin
        fifo_rd_en = rst_n && take && (grant_src == SRC_FIFO);
        cmd_ready  = rst_n && take && (grant_src == SRC_CMD);
        tx_start   = rst_n && (state_reg == ST_START);
    end

    // Byte capture, retry bookkeeping and the saturating gap/timeout timers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data_reg    <= 8'h00;
            retry_cnt_reg  <= '0;
            retry_pend_reg <= 1'b0;
            gap_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
        end else begin
            if (take) begin
                tx_data_reg <= (grant_src == SRC_CMD) ? cmd_data : fifo_data;
            end
            case (state_reg)
                ST_START: begin
                    to_cnt_reg     <= '0;
                    retry_pend_reg <= 1'b0;
                end
                ST_WAIT: begin
                    if (to_cnt_reg != '1) begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                    gap_cnt_reg <= '0;
                    if (wait_done) begin
                        retry_cnt_reg <= '0;
                    end else if (byte_drop) begin
                        retry_cnt_reg <= '0;
                    end else if (wait_fail) begin
                        retry_cnt_reg  <= retry_cnt_reg + RETRY_W'(1);
                        retry_pend_reg <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg != '1) begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data = tx_data_reg;
    assign state   = state_reg;

`ifdef PS2_SCHED_STATS_EN
    logic [15:0] sent_cnt_reg;
    logic [15:0] drop_cnt_reg;

    // Saturating counts of delivered and dropped bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sent_cnt_reg <= 16'h0000;
            drop_cnt_reg <= 16'h0000;
        end else begin
            if (wait_done && (sent_cnt_reg != 16'hFFFF)) begin
                sent_cnt_reg <= sent_cnt_reg + 16'd1;
            end
            if (byte_drop && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign sent_cnt = sent_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_ps2_tx_scheduler.sv
// Bench for ps2_tx_scheduler: byte sources and transmitter are modelled as
// queues; each scenario task checks its own expectations inline.
module tb_ps2_tx_scheduler;

    localparam int GAP  = 4;
    localparam int TMO  = 100;
    localparam int MAXR = 3;

    // kind: 0 done, 1 err, 2 done+err same cycle, 3 silent (timeout)
    typedef struct {
        int delay;
        int kind;
    } att_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_err = 1'b0;
    logic       fifo_rd_en;
    logic       cmd_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [2:0] state;
`ifdef PS2_SCHED_STATS_EN
    logic [15:0] sent_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] cmd_q[$];
    att_t       plan_q[$];
    int         start_cyc[$];
    logic [7:0] start_dat[$];
    int         fpop_cyc[$];
    int         cpop_cyc[$];
    att_t       cur;
    int         tx_cd = 0;
    bit         tx_pend = 1'b0;
    logic       mon_fr, mon_cr, mon_ts;

    ps2_tx_scheduler #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (MAXR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .state      (state)
`ifdef PS2_SCHED_STATS_EN
        ,
        .sent_cnt   (sent_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source and transmitter model: observe strobes mid-cycle, act after the edge.
    always begin
        @(negedge clk);
        mon_fr = fifo_rd_en;
        mon_cr = cmd_ready;
        mon_ts = tx_start;
        if (mon_fr) fpop_cyc.push_back(cyc);
        if (mon_cr) cpop_cyc.push_back(cyc);
        if (mon_ts) begin
            start_cyc.push_back(cyc);
            start_dat.push_back(tx_data);
            $display("tx_start cyc=%0d data=%02h", cyc, tx_data);
        end
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        tx_err  = 1'b0;
        if (mon_fr && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (mon_cr && cmd_q.size() > 0) void'(cmd_q.pop_front());
        if (mon_ts && plan_q.size() > 0) begin
            cur = plan_q.pop_front();
            tx_cd = cur.delay;
            tx_pend = 1'b1;
        end
        if (tx_pend) begin
            tx_cd--;
            if (tx_cd <= 0) begin
                tx_pend = 1'b0;
                if (cur.kind == 0 || cur.kind == 2) tx_done = 1'b1;
                if (cur.kind == 1 || cur.kind == 2) tx_err = 1'b1;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
        cmd_valid  = (cmd_q.size() != 0);
        cmd_data   = cmd_valid ? cmd_q[0] : 8'h00;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_log();
        start_cyc.delete();
        start_dat.delete();
        fpop_cyc.delete();
        cpop_cyc.delete();
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        tx_busy = 1'b0;
        tx_pend = 1'b0;
        plan_q.delete();
        fifo_q.delete();
        cmd_q.delete();
        tick(2);
    endtask

    task automatic release_reset(output int c0);
        tick(1);
        clear_log();
        rst_n = 1'b1;
        c0 = cyc;
    endtask

    task automatic wait_starts(input int n, input int budget, output bit expired);
        int k = 0;
        while (start_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        expired = (start_cyc.size() < n);
    endtask

    task automatic push_att(input int delay, input int kind);
        att_t a;
        a.delay = delay;
        a.kind  = kind;
        plan_q.push_back(a);
    endtask

    task automatic test_reset();
        hold_reset();
        fifo_q.push_back(8'hAA);
        cmd_q.push_back(8'h55);
        clear_log();
        tick(3);
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd_en: got %b want 0", fifo_rd_en); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (fpop_cyc.size() + cpop_cyc.size() != 0) begin errors++; $display("FAIL reset_pops: got %0d want 0", fpop_cyc.size() + cpop_cyc.size()); end
`ifdef PS2_SCHED_STATS_EN
        checks++; if (sent_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", sent_cnt, drop_cnt); end
`endif
    endtask

    task automatic test_fifo_only();
        int c0, s;
        bit exp;
        hold_reset();
        fifo_q.push_back(8'h1C);
        push_att(10, 0);
        release_reset(c0);
        wait_starts(1, 50, exp);
        checks++; if (exp) begin errors++; $display("FAIL fifo_only_start: got none want 1 start"); end
        checks++; if (fpop_cyc.size() != 1 || fpop_cyc[0] != c0) begin errors++; $display("FAIL fifo_only_pop: got n=%0d want 1 pop at cyc %0d", fpop_cyc.size(), c0); end
        s = c0 + 1;
        checks++; if (start_cyc.size() != 1 || start_cyc[0] != s) begin errors++; $display("FAIL fifo_only_start_cyc: got n=%0d want start at %0d", start_cyc.size(), s); end
        checks++; if (start_dat.size() != 1 || start_dat[0] !== 8'h1C) begin errors++; $display("FAIL fifo_only_data: got n=%0d want 1C", start_dat.size()); end
        while (cyc < s + GAP + 10) tick(1);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL fifo_only_gap: got %0d want 3", state); end
        tick(1);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL fifo_only_idle: got %0d want 0", state); end
    endtask

    task automatic test_round_robin();
        int c0;
        bit exp;
        hold_reset();
        fifo_q.push_back(8'h32);
        fifo_q.push_back(8'h21);
        cmd_q.push_back(8'hED);
        repeat (3) push_att(3, 0);
        release_reset(c0);
        wait_starts(3, 100, exp);
        checks++; if (exp) begin errors++; $display("FAIL rr_starts: got %0d want 3", start_cyc.size()); end
        checks++; if (start_dat.size() < 3 || start_dat[0] !== 8'h32 || start_dat[1] !== 8'hED || start_dat[2] !== 8'h21)
            begin errors++; $display("FAIL rr_order: got n=%0d want 32,ED,21", start_dat.size()); end
        checks++; if (fpop_cyc.size() != 2) begin errors++; $display("FAIL rr_fifo_pops: got %0d want 2", fpop_cyc.size()); end
        checks++; if (cpop_cyc.size() != 1) begin errors++; $display("FAIL rr_cmd_pops: got %0d want 1", cpop_cyc.size()); end
    endtask

    task automatic test_retry();
        int c0;
        bit exp;
        hold_reset();
        fifo_q.push_back(8'h5A);
        push_att(2, 1);
        push_att(3, 1);
        push_att(4, 0);
        release_reset(c0);
        wait_starts(3, 100, exp);
        tick(30);
        checks++; if (start_cyc.size() != 3) begin errors++; $display("FAIL retry_starts: got %0d want 3", start_cyc.size()); end
        for (int i = 0; i < start_dat.size(); i++) begin
            checks++; if (start_dat[i] !== 8'h5A) begin errors++; $display("FAIL retry_data[%0d]: got %02h want 5A", i, start_dat[i]); end
        end
        checks++; if (fpop_cyc.size() != 1) begin errors++; $display("FAIL retry_pops: got %0d want 1", fpop_cyc.size()); end
        if (start_cyc.size() >= 3) begin
            checks++; if (start_cyc[1] - start_cyc[0] != 2 + GAP + 1) begin errors++; $display("FAIL retry_space1: got %0d want %0d", start_cyc[1] - start_cyc[0], 2 + GAP + 1); end
            checks++; if (start_cyc[2] - start_cyc[1] != 3 + GAP + 1) begin errors++; $display("FAIL retry_space2: got %0d want %0d", start_cyc[2] - start_cyc[1], 3 + GAP + 1); end
        end
    endtask

    task automatic test_drop();
        int c0;
        bit exp;
        hold_reset();
        fifo_q.push_back(8'h77);
        cmd_q.push_back(8'hFF);
        repeat (4) push_att(2, 1);
        push_att(2, 0);
        release_reset(c0);
        wait_starts(5, 150, exp);
        tick(15);
        checks++; if (start_cyc.size() != 5) begin errors++; $display("FAIL drop_starts: got %0d want 5", start_cyc.size()); end
        if (start_cyc.size() == 5) begin
            checks++; if (start_dat[3] !== 8'h77 || start_dat[4] !== 8'hFF) begin errors++; $display("FAIL drop_data: got %02h,%02h want 77,FF", start_dat[3], start_dat[4]); end
            checks++; if (start_cyc[4] - start_cyc[3] != 2 + GAP + 2) begin errors++; $display("FAIL drop_space: got %0d want %0d", start_cyc[4] - start_cyc[3], 2 + GAP + 2); end
        end
        checks++; if (fpop_cyc.size() != 1 || cpop_cyc.size() != 1) begin errors++; $display("FAIL drop_pops: got %0d/%0d want 1/1", fpop_cyc.size(), cpop_cyc.size()); end
`ifdef PS2_SCHED_STATS_EN
        checks++; if (drop_cnt !== 16'd1 || sent_cnt !== 16'd1) begin errors++; $display("FAIL drop_stats: got %0d/%0d want 1/1", sent_cnt, drop_cnt); end
`endif
    endtask

    task automatic test_timeout();
        int c0;
        bit exp;
        hold_reset();
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        push_att(1, 3);
        push_att(5, 2);
        push_att(3, 0);
        release_reset(c0);
        wait_starts(3, 300, exp);
        checks++; if (exp) begin errors++; $display("FAIL timeout_starts: got %0d want 3", start_cyc.size()); end
        if (start_cyc.size() >= 3) begin
            checks++; if (start_cyc[1] - start_cyc[0] != TMO + GAP + 1) begin errors++; $display("FAIL timeout_space: got %0d want %0d", start_cyc[1] - start_cyc[0], TMO + GAP + 1); end
            checks++; if (start_dat[1] !== 8'h11) begin errors++; $display("FAIL timeout_retry_data: got %02h want 11", start_dat[1]); end
            checks++; if (start_cyc[2] - start_cyc[1] != 5 + GAP + 2) begin errors++; $display("FAIL both_pulse_space: got %0d want %0d", start_cyc[2] - start_cyc[1], 5 + GAP + 2); end
            checks++; if (start_dat[2] !== 8'h22) begin errors++; $display("FAIL both_pulse_next: got %02h want 22", start_dat[2]); end
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        bit exp;
        hold_reset();
        fifo_q.push_back(8'h44);
        fifo_q.push_back(8'h66);
        push_att(30, 0);
        push_att(3, 0);
        release_reset(c0);
        wait_starts(1, 20, exp);
        tick(5);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL mid_in_wait: got %0d want 2", state); end
        rst_n = 1'b0;
        tx_pend = 1'b0;
        tick(1);
        checks++; if (fifo_rd_en !== 1'b0 || cmd_ready !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL mid_strobes: got %b%b%b want 000", fifo_rd_en, cmd_ready, tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data: got %02h want 00", tx_data); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_state: got %0d want 0", state); end
        tick(2);
        checks++; if (fpop_cyc.size() != 1) begin errors++; $display("FAIL mid_no_pop: got %0d want 1", fpop_cyc.size()); end
        rst_n = 1'b1;
        wait_starts(2, 30, exp);
        checks++; if (start_dat.size() != 2 || start_dat[1] !== 8'h66) begin errors++; $display("FAIL mid_next: got n=%0d want second start 66", start_dat.size()); end
        checks++; if (fpop_cyc.size() != 2) begin errors++; $display("FAIL mid_pops: got %0d want 2", fpop_cyc.size()); end
    endtask

    task automatic test_busy();
        int c0, b;
        bit exp;
        hold_reset();
        tx_busy = 1'b1;
        fifo_q.push_back(8'h3C);
        push_att(2, 0);
        release_reset(c0);
        tick(10);
        checks++; if (fpop_cyc.size() != 0 || state !== 3'd0) begin errors++; $display("FAIL busy_hold: got pops=%0d state=%0d want 0/0", fpop_cyc.size(), state); end
        tx_busy = 1'b0;
        b = cyc;
        wait_starts(1, 20, exp);
        checks++; if (exp || start_cyc[0] != b + 1 || start_dat[0] !== 8'h3C) begin errors++; $display("FAIL busy_release: got n=%0d want 3C at %0d", start_cyc.size(), b + 1); end
    endtask

    task automatic test_random();
        int c0, nf, nc, fi, ci, ptr, src, k, t, off_prev, drops;
        bit first, exp;
        logic [7:0] b;
        logic [7:0] fbytes[$];
        logic [7:0] cbytes[$];
        logic [7:0] exp_data[$];
        int exp_off[$];
        att_t a;
        for (int it = 0; it < 6; it++) begin
            hold_reset();
            fbytes.delete(); cbytes.delete(); exp_data.delete(); exp_off.delete();
            nf = $urandom_range(0, 4);
            nc = $urandom_range(0, 4);
            if (nf + nc == 0) nf = 1;
            for (int i = 0; i < nf; i++) begin b = 8'($urandom_range(0, 255)); fbytes.push_back(b); fifo_q.push_back(b); end
            for (int i = 0; i < nc; i++) begin b = 8'($urandom_range(0, 255)); cbytes.push_back(b); cmd_q.push_back(b); end
            // Reference: round-robin grant order, retries per byte, start spacing.
            fi = 0; ci = 0; ptr = 0; t = 0; off_prev = 0; first = 1'b1; drops = 0;
            while (fi < nf || ci < nc) begin
                if (fi < nf && ci < nc) begin src = ptr; ptr = 1 - ptr; end
                else src = (fi < nf) ? 0 : 1;
                if (src == 0) begin b = fbytes[fi]; fi++; end
                else begin b = cbytes[ci]; ci++; end
                k = $urandom_range(0, MAXR + 1);
                for (int n = 0; n <= k && n <= MAXR; n++) begin
                    if (!first) t += off_prev + GAP + ((n == 0) ? 2 : 1);
                    first = 1'b0;
                    exp_data.push_back(b);
                    exp_off.push_back(t);
                    a.delay = $urandom_range(1, 8);
                    if (n < k) a.kind = ($urandom_range(0, 7) == 0) ? 3 : 1;
                    else a.kind = ($urandom_range(0, 3) == 0) ? 2 : 0;
                    off_prev = (a.kind == 3) ? TMO : a.delay;
                    plan_q.push_back(a);
                end
                if (k > MAXR) drops++;
            end
            release_reset(c0);
            wait_starts(exp_data.size(), exp_data.size() * (TMO + GAP + 12), exp);
            tick(TMO + GAP + 10);
            checks++; if (start_cyc.size() != exp_data.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", it, start_cyc.size(), exp_data.size()); end
            for (int i = 0; i < exp_data.size(); i++) begin
                if (i < start_cyc.size()) begin
                    checks++; if (start_dat[i] !== exp_data[i]) begin errors++; $display("FAIL rand%0d_data[%0d]: got %02h want %02h", it, i, start_dat[i], exp_data[i]); end
                    checks++; if (start_cyc[i] - start_cyc[0] != exp_off[i]) begin errors++; $display("FAIL rand%0d_time[%0d]: got %0d want %0d", it, i, start_cyc[i] - start_cyc[0], exp_off[i]); end
                end
            end
            checks++; if (fpop_cyc.size() != nf || cpop_cyc.size() != nc) begin errors++; $display("FAIL rand%0d_pops: got %0d/%0d want %0d/%0d", it, fpop_cyc.size(), cpop_cyc.size(), nf, nc); end
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL rand%0d_idle: got %0d want 0", it, state); end
`ifdef PS2_SCHED_STATS_EN
            checks++; if (drop_cnt !== 16'(drops) || sent_cnt !== 16'(nf + nc - drops)) begin errors++; $display("FAIL rand%0d_stats: got %0d/%0d want %0d/%0d", it, sent_cnt, drop_cnt, nf + nc - drops, drops); end
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fifo_only();
        test_round_robin();
        test_retry();
        test_drop();
        test_timeout();
        test_reset_mid();
        test_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
